// File: rtl/cla_pkg.sv
// cla_pkg: shared constants and helpers for the pipelined carry-lookahead adder
package cla_pkg;
    localparam int MAX_GROUP = 8;
    function automatic int ngroups(input int width, input int group);
        return width / group;
    endfunction
endpackage

// File: rtl/cla_adder_pipe_group.sv
// cla_group: combinational N-bit carry-lookahead unit
// Ports: i_p/i_g per-bit propagate/generate, i_c group carry-in;
//        o_p/o_g group propagate/generate, o_c carry into each bit.
module cla_group #(
    parameter int N = 4
) (
    input  logic [N-1:0] i_p,
    input  logic [N-1:0] i_g,
    input  logic         i_c,
    output logic         o_p,
    output logic         o_g,
    output logic [N-1:0] o_c
);
    logic w_t;
    // Each carry is a flat sum of products: g[j] qualified by every p above j, plus c_in through all p below i.
    always_comb begin
        w_t = 1'b1;
        o_p = &i_p;
        o_g = 1'b0;
        o_c = '0;
        for (int i = 0; i < N; i++) begin
            w_t = 1'b1;
            for (int j = i - 1; j >= 0; j--) begin
                o_c[i] = o_c[i] | (w_t & i_g[j]);
                w_t = w_t & i_p[j];
            end
            o_c[i] = o_c[i] | (w_t & i_c);
        end
        w_t = 1'b1;
        for (int j = N - 1; j >= 0; j--) begin
            o_g = o_g | (w_t & i_g[j]);
            w_t = w_t & i_p[j];
        end
    end
endmodule

// File: rtl/cla_adder_pipe.sv
// cla_adder_pipe: 3-stage pipelined carry-lookahead adder with valid/ready backpressure
// Ports: clk, rst_n (async active-low); in_valid/in_ready, a, b, c_in upstream;
//        out_valid/out_ready, sum, c_out downstream.
// Macro CLA_PIPE_OVF_EN adds output ovf (signed overflow, registered with sum).
module cla_adder_pipe
    import cla_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int GROUP = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             c_out
`ifdef CLA_PIPE_OVF_EN
    ,
    output logic             ovf
`endif
);
    localparam int NG = ngroups(WIDTH, GROUP);
    typedef struct packed {
        logic [WIDTH-1:0] p;
        logic [WIDTH-1:0] g;
        logic [NG:0]      c;
    } payload_t;
    if (WIDTH % GROUP != 0 || GROUP < 2 || GROUP > MAX_GROUP) begin : g_bad_cfg
        $error("cla_adder_pipe: WIDTH must be a multiple of GROUP and GROUP in 2..8");
    end
    logic             w_en1, w_en2, w_en3;
    logic [WIDTH-1:0] w_p0, w_g0, w_c3;
    logic [NG-1:0]    w_gp, w_gg;
    logic [NG:0]      w_c2;
    logic [WIDTH-1:0] w_s1_c_unused;
    logic [NG-1:0]    w_s3_p_unused, w_s3_g_unused;
    logic             r_v1, r_v2, r_v3, r_c1;
    logic [WIDTH-1:0] r_p1, r_g1;
    logic [NG-1:0]    r_gp1, r_gg1;
    payload_t         r_s2;
    assign w_en3     = !r_v3 | out_ready;
    assign w_en2     = !r_v2 | w_en3;
    assign w_en1     = !r_v1 | w_en2;
    assign in_ready  = w_en1;
    assign out_valid = r_v3;
    assign w_p0      = a ^ b;
    assign w_g0      = a & b;
    // Group carry-ins ripple across groups; in-group carries are lookahead in S3.
    always_comb begin
        w_c2    = '0;
        w_c2[0] = r_c1;
        for (int k = 0; k < NG; k++) w_c2[k+1] = r_gg1[k] | (r_gp1[k] & w_c2[k]);
    end
    for (genvar k = 0; k < NG; k++) begin : g_grp
        cla_group #(.N(GROUP)) u_s1 (
            .i_p(w_p0[k*GROUP +: GROUP]),
            .i_g(w_g0[k*GROUP +: GROUP]),
            .i_c(1'b0),
            .o_p(w_gp[k]),
            .o_g(w_gg[k]),
            .o_c(w_s1_c_unused[k*GROUP +: GROUP])
        );
        cla_group #(.N(GROUP)) u_s3 (
            .i_p(r_s2.p[k*GROUP +: GROUP]),
            .i_g(r_s2.g[k*GROUP +: GROUP]),
            .i_c(r_s2.c[k]),
            .o_p(w_s3_p_unused[k]),
            .o_g(w_s3_g_unused[k]),
            .o_c(w_c3[k*GROUP +: GROUP])
        );
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_v1  <= 1'b0;
            r_v2  <= 1'b0;
            r_v3  <= 1'b0;
            r_p1  <= '0;
            r_g1  <= '0;
            r_gp1 <= '0;
            r_gg1 <= '0;
            r_c1  <= 1'b0;
            r_s2  <= '0;
            sum   <= '0;
            c_out <= 1'b0;
`ifdef CLA_PIPE_OVF_EN
            ovf   <= 1'b0;
`endif
        end else begin
            if (w_en1) begin
                r_v1 <= in_valid;
                if (in_valid) begin
                    r_p1  <= w_p0;
                    r_g1  <= w_g0;
                    r_gp1 <= w_gp;
                    r_gg1 <= w_gg;
                    r_c1  <= c_in;
                end
            end
            if (w_en2) begin
                r_v2 <= r_v1;
                if (r_v1) r_s2 <= '{p: r_p1, g: r_g1, c: w_c2};
            end
            if (w_en3) begin
                r_v3 <= r_v2;
                if (r_v2) begin
                    sum   <= r_s2.p ^ w_c3;
                    c_out <= r_s2.c[NG];
`ifdef CLA_PIPE_OVF_EN
                    ovf   <= w_c3[WIDTH-1] ^ r_s2.c[NG];
`endif
                end
            end
        end
    end
endmodule
